mcu_control_unit: RTL and testbench

Multi-cycle fetch/execute controller for the 8-bit MCU, sitting directly upstream of the ALU. It fetches 8-bit instructions from a combinational program ROM and drives the ALU's operand and select inputs. It writes the ALU result and carry/zero outputs back into an accumulator and flag registers it owns. It also handles jumps, output-port writes and halt.

---
 rtl/mcu_pkg.sv | 46 ++++
 rtl/mcu_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_mcu_control_unit.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit MCU: ALU select codes, opcodes, control FSM states.
// Used by the control unit and by the ALU.
package mcu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;
    localparam logic [1:0] ALU_NOR = 2'b01;
    localparam logic [1:0] ALU_NUL = 2'b00;

    localparam logic [1:0] LS_SHL = 2'b01;
    localparam logic [1:0] LS_SHR = 2'b11;
    localparam logic [1:0] LS_LD  = 2'b10;
    localparam logic [1:0] LS_RST = 2'b00;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_NORI = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_CLR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        OPERAND = 2'd1,
        EXEC    = 2'd2,
        HALT    = 2'd3
    } state_t;

    function automatic logic is_two_byte(input logic [3:0] opcode);
        logic w_two;
        case (opcode)
            OP_LDI, OP_ADDI, OP_SUBI, OP_NORI,
            OP_JMP, OP_JZ, OP_JC: w_two = 1'b1;
            default:              w_two = 1'b0;
        endcase
        return w_two;
    endfunction

endpackage

// File: rtl/mcu_control_unit.sv
// Multi-cycle fetch/operand/execute controller driving the external ALU and
// owning pc, ir/opr, accumulator, flags and the output port register.
module mcu_control_unit
    import mcu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    output logic [7:0] pc,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_sel,
    output logic [1:0] load_shift,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    input  logic       alu_zout,
    output logic [7:0] acc,
    output logic       c_flag,
    output logic       z_flag,
    output logic [7:0] out_port,
    output logic       out_valid,
    output logic       halted
);

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_opr;
    logic [7:0] r_acc;
    logic       r_c;
    logic       r_z;
    logic [7:0] r_out;
    logic       r_out_valid;
    logic       r_halted;

    state_t     w_state_nxt;
    logic [7:0] w_pc_nxt;
    logic [7:0] w_ir_nxt;
    logic [7:0] w_opr_nxt;
    logic [7:0] w_acc_nxt;
    logic       w_c_nxt;
    logic       w_z_nxt;
    logic [7:0] w_out_nxt;
    logic       w_out_valid_nxt;
    logic       w_halted_nxt;
    logic [7:0] w_alu_a;
    logic [7:0] w_alu_b;
    logic [1:0] w_alu_sel;
    logic [1:0] w_ls;
    logic       w_alu_op;
    logic [3:0] w_op;
    logic       w_unused_ir;

    assign w_op        = r_ir[7:4];
    assign w_unused_ir = ^r_ir[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_opr_nxt       = r_opr;
        w_acc_nxt       = r_acc;
        w_c_nxt         = r_c;
        w_z_nxt         = r_z;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_halted_nxt    = r_halted;
        w_alu_a         = r_acc;
        w_alu_b         = '0;
        w_alu_sel       = ALU_NUL;
        w_ls            = LS_RST;
        w_alu_op        = 1'b0;

        case (r_state)
            FETCH: begin
                w_ir_nxt    = instr;
                w_pc_nxt    = r_pc + 8'd1;
                w_state_nxt = is_two_byte(instr[7:4]) ? OPERAND : EXEC;
            end
            OPERAND: begin
                w_opr_nxt   = instr;
                w_pc_nxt    = r_pc + 8'd1;
                w_state_nxt = EXEC;
            end
            EXEC: begin
                w_state_nxt = FETCH;
                case (w_op)
                    OP_LDI: begin
                        w_alu_op = 1'b1;
                        w_alu_a  = r_opr;
                        w_alu_b  = r_opr;
                        w_ls     = LS_LD;
                    end
                    OP_ADDI: begin
                        w_alu_op  = 1'b1;
                        w_alu_b   = r_opr;
                        w_alu_sel = ALU_ADD;
                    end
                    OP_SUBI: begin
                        w_alu_op  = 1'b1;
                        w_alu_b   = r_opr;
                        w_alu_sel = ALU_SUB;
                    end
                    OP_NORI: begin
                        w_alu_op  = 1'b1;
                        w_alu_b   = r_opr;
                        w_alu_sel = ALU_NOR;
                    end
                    OP_SHL: begin
                        w_alu_op = 1'b1;
                        w_alu_b  = r_opr;
                        w_ls     = LS_SHL;
                    end
                    OP_SHR: begin
                        w_alu_op = 1'b1;
                        w_alu_b  = r_opr;
                        w_ls     = LS_SHR;
                    end
                    OP_CLR: begin
                        w_alu_op = 1'b1;
                        w_alu_b  = r_opr;
                    end
                    OP_JMP: w_pc_nxt = r_opr;
                    // Conditional jumps test the flags as they stood before this EXEC
                    OP_JZ:  if (r_z) w_pc_nxt = r_opr;
                    OP_JC:  if (r_c) w_pc_nxt = r_opr;
                    OP_OUT: begin
                        w_out_nxt       = r_acc;
                        w_out_valid_nxt = 1'b1;
                    end
                    OP_HLT: begin
                        w_state_nxt  = HALT;
                        w_halted_nxt = 1'b1;
                    end
                    default: ;
                endcase
                if (w_alu_op) begin
                    w_acc_nxt = alu_result;
                    w_c_nxt   = alu_cout;
                    w_z_nxt   = alu_zout;
                end
            end
            HALT: w_state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_opr       <= '0;
            r_acc       <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_opr       <= w_opr_nxt;
            r_acc       <= w_acc_nxt;
            r_c         <= w_c_nxt;
            r_z         <= w_z_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

    assign pc         = r_pc;
    assign alu_a      = w_alu_a;
    assign alu_b      = w_alu_b;
    assign alu_sel    = w_alu_sel;
    assign load_shift = w_ls;
    assign acc        = r_acc;
    assign c_flag     = r_c;
    assign z_flag     = r_z;
    assign out_port   = r_out;
    assign out_valid  = r_out_valid;
    assign halted     = r_halted;

endmodule

// File: tb/tb_mcu_control_unit.sv
// Self-checking bench: directed programs plus random ROM images, compared
// instruction-by-instruction against an instruction-level reference model.
module tb_mcu_control_unit;

    localparam logic [7:0] TB_RESET_PC = 8'h00;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [1:0] load_shift;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       alu_zout;
    logic [7:0] acc;
    logic       c_flag;
    logic       z_flag;
    logic [7:0] out_port;
    logic       out_valid;
    logic       halted;

    logic [7:0] rom [256];

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] m_pc;
    logic [7:0] m_acc;
    logic       m_c;
    logic       m_z;
    logic [7:0] m_out;
    logic       m_ov;
    logic       m_halt;
    logic       prev_ov;

    mcu_control_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .pc         (pc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .load_shift (load_shift),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_zout   (alu_zout),
        .acc        (acc),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr = rom[pc];

    // Behavioural ALU standing in for the real one downstream
    always_comb begin
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        case (alu_sel)
            2'b10: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b11: begin
                alu_result = alu_a - alu_b;
                alu_cout   = (alu_a < alu_b);
            end
            2'b01: alu_result = ~(alu_a | alu_b);
            default: begin
                case (load_shift)
                    2'b01: begin alu_result = {alu_a[6:0], 1'b0}; alu_cout = alu_a[7]; end
                    2'b11: begin alu_result = {1'b0, alu_a[7:1]}; alu_cout = alu_a[0]; end
                    2'b10: alu_result = alu_a;
                    default: alu_result = 8'h00;
                endcase
            end
        endcase
        alu_zout = (alu_result == 8'h00);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk1("out_valid_back_to_back", prev_ov & out_valid, 1'b0);
        prev_ov = out_valid;
    endtask

    task automatic model_reset();
        m_pc   = TB_RESET_PC;
        m_acc  = 8'h00;
        m_c    = 1'b0;
        m_z    = 1'b0;
        m_out  = 8'h00;
        m_ov   = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_pc", pc, TB_RESET_PC);
        chk("rst_acc", acc, 8'h00);
        chk1("rst_c", c_flag, 1'b0);
        chk1("rst_z", z_flag, 1'b0);
        chk("rst_out_port", out_port, 8'h00);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_alu_sel", {6'b0, alu_sel}, 8'h00);
        chk("rst_load_shift", {6'b0, load_shift}, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        model_reset();
        prev_ov = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic set_res(input logic [7:0] v, input logic c);
        m_acc = v;
        m_c   = c;
        m_z   = (v == 8'h00);
    endtask

    // One whole instruction at ISA level; returns its cycle count
    task automatic model_step(output int cyc);
        logic [3:0] op;
        logic [7:0] opr;
        logic [8:0] s;
        m_ov = 1'b0;
        opr  = 8'h00;
        if (m_halt) begin
            cyc = 1;
            return;
        end
        op   = rom[m_pc][7:4];
        m_pc = m_pc + 8'd1;
        cyc  = 2;
        if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA}) begin
            opr  = rom[m_pc];
            m_pc = m_pc + 8'd1;
            cyc  = 3;
        end
        case (op)
            4'h1: set_res(opr, 1'b0);
            4'h2: begin
                s = {1'b0, m_acc} + {1'b0, opr};
                set_res(s[7:0], s[8]);
            end
            4'h3: set_res(m_acc - opr, m_acc < opr);
            4'h4: set_res(~(m_acc | opr), 1'b0);
            4'h5: set_res(m_acc << 1, m_acc[7]);
            4'h6: set_res(m_acc >> 1, m_acc[0]);
            4'h7: set_res(8'h00, 1'b0);
            4'h8: m_pc = opr;
            4'h9: if (m_z) m_pc = opr;
            4'hA: if (m_c) m_pc = opr;
            4'hB: begin m_out = m_acc; m_ov = 1'b1; end
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run_instr();
        int cyc;
        model_step(cyc);
        repeat (cyc) tick();
        chk("pc", pc, m_pc);
        chk("acc", acc, m_acc);
        chk1("c_flag", c_flag, m_c);
        chk1("z_flag", z_flag, m_z);
        chk("out_port", out_port, m_out);
        chk1("out_valid", out_valid, m_ov);
        chk1("halted", halted, m_halt);
    endtask

    task automatic put(input logic [7:0] addr, input logic [7:0] b0, input logic [7:0] b1, input bit two);
        rom[addr] = b0;
        if (two) rom[addr + 8'd1] = b1;
    endtask

    initial begin
        rst_n   = 1'b1;
        prev_ov = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        put(8'h00, 8'h80, 8'h50, 1);
        put(8'h50, 8'h10, 8'h5A, 1);
        put(8'h52, 8'h10, 8'hF0, 1);
        put(8'h54, 8'h20, 8'h20, 1);
        put(8'h56, 8'h30, 8'h10, 1);
        put(8'h58, 8'h30, 8'h01, 1);
        put(8'h5A, 8'h10, 8'h81, 1);
        put(8'h5C, 8'h50, 8'h00, 0);
        put(8'h5D, 8'h60, 8'h00, 0);
        put(8'h5E, 8'h70, 8'h00, 0);
        put(8'h5F, 8'h40, 8'h0F, 1);
        put(8'h61, 8'h70, 8'h00, 0);
        put(8'h62, 8'h90, 8'h40, 1);
        put(8'h40, 8'h10, 8'h01, 1);
        put(8'h42, 8'h90, 8'h30, 1);
        put(8'h44, 8'h10, 8'hFF, 1);
        put(8'h46, 8'h20, 8'h01, 1);
        put(8'h48, 8'hA0, 8'hF0, 1);
        put(8'hF0, 8'h80, 8'hFE, 1);
        put(8'hFE, 8'h00, 8'h00, 0);
        put(8'hFF, 8'h10, 8'h00, 0);
        put(8'h01, 8'h50, 8'h00, 0);
        put(8'h02, 8'h80, 8'h70, 1);
        put(8'h70, 8'h10, 8'h33, 1);
        put(8'h72, 8'hB0, 8'h00, 0);
        put(8'h73, 8'hC0, 8'h00, 0);
        put(8'h74, 8'hF0, 8'h00, 0);

        #6;
        do_reset();

        run_instr();                                   // JMP 50
        run_instr();                                   // LDI 5A
        chk("ldi_acc", acc, 8'h5A);
        chk("ldi_pc", pc, 8'h52);
        run_instr();                                   // LDI F0
        run_instr();                                   // ADDI 20
        chk("addi_acc", acc, 8'h10);
        chk1("addi_c", c_flag, 1'b1);
        run_instr();                                   // SUBI 10
        chk1("subi_z", z_flag, 1'b1);
        run_instr();                                   // SUBI 01 borrow
        chk("subi_borrow_acc", acc, 8'hFF);
        chk1("subi_borrow_c", c_flag, 1'b1);
        run_instr();                                   // LDI 81
        run_instr();                                   // SHL
        chk("shl_acc", acc, 8'h02);
        run_instr();                                   // SHR
        chk("shr_acc", acc, 8'h01);
        run_instr();                                   // CLR
        run_instr();                                   // NORI 0F
        chk("nori_acc", acc, 8'hF0);
        run_instr();                                   // CLR
        run_instr();                                   // JZ taken
        chk("jz_taken_pc", pc, 8'h40);
        run_instr();                                   // LDI 01
        run_instr();                                   // JZ not taken
        chk("jz_not_taken_pc", pc, 8'h44);
        run_instr();                                   // LDI FF
        run_instr();                                   // ADDI 01
        run_instr();                                   // JC taken
        chk("jc_taken_pc", pc, 8'hF0);
        run_instr();                                   // JMP FE
        run_instr();                                   // NOP at FE
        run_instr();                                   // LDI with operand fetched across wrap
        chk("wrap_operand_acc", acc, 8'h80);
        chk("wrap_pc", pc, 8'h01);
        run_instr();                                   // SHL
        run_instr();                                   // JMP 70
        run_instr();                                   // LDI 33
        run_instr();                                   // OUT
        chk("out_port_val", out_port, 8'h33);
        chk1("out_valid_pulse", out_valid, 1'b1);
        tick();
        chk1("out_valid_drop", out_valid, 1'b0);
        m_ov = 1'b0;
        repeat (1) begin
            int cyc;
            model_step(cyc);                           // NOP C0 (one cycle already consumed)
            repeat (cyc - 1) tick();
            chk("c0_nop_pc", pc, 8'h74);
            chk("c0_nop_acc", acc, m_acc);
        end
        run_instr();                                   // HLT
        chk1("hlt_halted", halted, 1'b1);
        chk("hlt_pc", pc, 8'h75);
        repeat (20) run_instr();
        do_reset();
        run_instr();
        chk("restart_pc", pc, 8'h50);

        // reset while ADDI sits in OPERAND
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        put(8'h00, 8'h10, 8'h44, 1);
        put(8'h02, 8'h20, 8'h11, 1);
        tick();
        do_reset();
        run_instr();
        chk("midrst_pre_acc", acc, 8'h44);
        tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_acc", acc, 8'h00);
        chk("midrst_pc", pc, TB_RESET_PC);
        chk1("midrst_c", c_flag, 1'b0);
        chk1("midrst_z", z_flag, 1'b0);
        rst_n = 1'b1;
        model_reset();
        prev_ov = 1'b0;
        run_instr();
        run_instr();
        chk("midrst_addi_acc", acc, 8'h55);

        // random ROM images
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 256; a++) begin
                rom[a] = 8'($urandom);
                if (rom[a][7:4] == 4'hF && $urandom_range(0, 3) != 0)
                    rom[a] = 8'h20;
            end
            tick();
            do_reset();
            repeat (80) run_instr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
